// File: rtl/elevator_car_controller.sv
// elevator_car_controller: car motion and door sequencer with registered Moore outputs.
// Optional ELEVATOR_DOOR_REOPEN_EN: a rising OCRequest while the door is open restarts the dwell.
module elevator_car_controller #(
    parameter int TRAVEL_CYCLES = 1000,
    parameter int DOOR_CYCLES   = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       OCRequest,
    input  logic       UDRequest,
    input  logic       NoStopRequest,
    input  logic       DoneDelay,
    output logic [1:0] CurrentFloor,
    output logic       UDIn,
    output logic       Delay,
    output logic       Stop,
    output logic       DoorOpen,
    output logic       Moving
);
    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW = $clog2(MAX_CYCLES) + 1;
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYCLES - 1);

    // One-hot encoding: each state bit is itself a flop, so the status outputs are glitch-free.
    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        MOVE   = 4'b0010,
        ARRIVE = 4'b0100,
        DOOR   = 4'b1000
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [1:0]    floor, floor_nxt;
    logic          ud, ud_nxt;
    logic          legal_move;
    logic          door_restart;

    // A request toward the end the car already sits at is not a move.
    assign legal_move = UDRequest ? (floor != 2'd3) : (floor != 2'd0);

`ifdef ELEVATOR_DOOR_REOPEN_EN
    logic oc_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) oc_prev <= 1'b0;
        else     oc_prev <= OCRequest;
    end

    assign door_restart = OCRequest & ~oc_prev;
`else
    assign door_restart = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
            floor <= 2'd0;
            ud    <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            floor <= floor_nxt;
            ud    <= ud_nxt;
        end
    end

    // NOTE: every variable gets its default first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        floor_nxt = floor;
        ud_nxt    = ud;
        unique case (state)
            IDLE: begin
                if (NoStopRequest) begin
                    if (legal_move) begin
                        state_nxt = MOVE;
                        ud_nxt    = UDRequest;
                        timer_nxt = '0;
                    end else begin
                        state_nxt = ARRIVE;
                    end
                end
            end
            MOVE: begin
                if (timer == TRAVEL_LAST) begin
                    state_nxt = ARRIVE;
                    timer_nxt = '0;
                    floor_nxt = ud ? floor + 2'd1 : floor - 2'd1;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            ARRIVE: begin
                if (DoneDelay) begin
                    if (OCRequest) begin
                        state_nxt = DOOR;
                        timer_nxt = '0;
                    end else if (NoStopRequest && legal_move) begin
                        state_nxt = MOVE;
                        ud_nxt    = UDRequest;
                        timer_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DOOR: begin
                if (door_restart) begin
                    timer_nxt = '0;
                end else if (timer == DOOR_LAST) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    always_comb begin
        Stop         = state[0];
        Moving       = state[1];
        Delay        = state[2];
        DoorOpen     = state[3];
        CurrentFloor = floor;
        UDIn         = ud;
    end

endmodule

// File: tb/tb_elevator_car_controller.sv
// Scoreboard bench for elevator_car_controller: a floor-level model predicts arrivals, ARRIVE
// hold times and door dwells; a negedge monitor compares each event as the DUT presents it.
module tb_elevator_car_controller;
    localparam int TRAVEL = 4;
    localparam int DWELL  = 3;

    typedef struct {
        int floor;
        int ud;
        int move_len;
    } arrival_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       OCRequest = 1'b0;
    logic       UDRequest = 1'b0;
    logic       NoStopRequest = 1'b0;
    logic       DoneDelay = 1'b0;
    logic [1:0] CurrentFloor;
    logic       UDIn, Delay, Stop, DoorOpen, Moving;

    int checks = 0;
    int failures = 0;

    arrival_t arr_q[$];
    int       dly_q[$];
    int       door_q[$];

    int m_floor = 0;
    int m_ud = 0;

    elevator_car_controller #(.TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DWELL)) dut (
        .clk(clk), .rst(rst), .OCRequest(OCRequest), .UDRequest(UDRequest),
        .NoStopRequest(NoStopRequest), .DoneDelay(DoneDelay), .CurrentFloor(CurrentFloor),
        .UDIn(UDIn), .Delay(Delay), .Stop(Stop), .DoorOpen(DoorOpen), .Moving(Moving)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_floor"}, int'(CurrentFloor), 0);
        check({tag, "_stop"}, int'(Stop), 1);
        check({tag, "_moving"}, int'(Moving), 0);
        check({tag, "_delay"}, int'(Delay), 0);
        check({tag, "_door"}, int'(DoorOpen), 0);
        check({tag, "_udin"}, int'(UDIn), 0);
    endtask

    // Model: a legal request moves one floor in TRAVEL cycles; an illegal one arrives in place.
    task automatic expect_arrival(input int dir, output bit legal);
        arrival_t a;
        legal = (dir == 1) ? (m_floor < 3) : (m_floor > 0);
        if (legal) begin
            m_floor = (dir == 1) ? m_floor + 1 : m_floor - 1;
            m_ud = dir;
        end
        a.floor = m_floor;
        a.ud = m_ud;
        a.move_len = legal ? TRAVEL : 0;
        arr_q.push_back(a);
    endtask

    // Called just after a negedge with the car idle.
    task automatic start_trip(input int dir);
        bit legal;
        NoStopRequest = 1'b1;
        UDRequest = dir[0];
        expect_arrival(dir, legal);
        @(negedge clk);
        NoStopRequest = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 50 && !Stop; i++) @(negedge clk);
        check({tag, "_reach_idle"}, int'(Stop), 1);
        check({tag, "_idle_floor"}, int'(CurrentFloor), m_floor);
    endtask

    // choice: 0 door, 1 continue in direction dir, 2 go idle, 3 door with a reopen pulse.
    task automatic arrive_exit(input int choice, input int dir, output bit more);
        int  k;
        bit  legal;
        more = 1'b0;
        for (int i = 0; i < 50 && !Delay; i++) @(negedge clk);
        if (!Delay) begin
            check("arrive_timeout", int'(Delay), 1);
            return;
        end
        k = $urandom_range(0, 3);
        repeat (k) @(negedge clk);
        dly_q.push_back(k + 1);
        DoneDelay = 1'b1;
        case (choice)
            0, 3: begin
                OCRequest = 1'b1;
                NoStopRequest = 1'($urandom_range(0, 1));
                UDRequest = 1'($urandom_range(0, 1));
`ifdef ELEVATOR_DOOR_REOPEN_EN
                door_q.push_back((choice == 3) ? DWELL + 2 : DWELL);
`else
                door_q.push_back(DWELL);
`endif
            end
            1: begin
                OCRequest = 1'b0;
                NoStopRequest = 1'b1;
                UDRequest = dir[0];
                expect_arrival(dir, legal);
                if (!legal) void'(arr_q.pop_back());
                more = legal;
            end
            default: begin
                OCRequest = 1'b0;
                NoStopRequest = 1'b0;
            end
        endcase
        @(negedge clk);
        DoneDelay = 1'b0;
        OCRequest = 1'b0;
        NoStopRequest = 1'b0;
        if (choice == 3) begin
            @(negedge clk);
            OCRequest = 1'b1;
            @(negedge clk);
            OCRequest = 1'b0;
        end
        if (!more) wait_idle("exit");
    endtask

    // Monitor: per-cycle one-hot status, plus event comparisons against the scoreboard queues.
    initial begin
        int move_cnt = 0, dly_cnt = 0, door_cnt = 0;
        logic prev_delay = 1'b0, prev_door = 1'b0;
        arrival_t a;
        int exp_len;
        forever begin
            @(negedge clk);
            if (rst) begin
                move_cnt = 0;
                dly_cnt = 0;
                door_cnt = 0;
                prev_delay = 1'b0;
                prev_door = 1'b0;
            end else begin
                check("onehot_status", $countones({Stop, Moving, Delay, DoorOpen}), 1);
                if (Moving) move_cnt++;
                if (Delay && !prev_delay) begin
                    if (arr_q.size() == 0) begin
                        check("unexpected_arrival", 1, 0);
                    end else begin
                        a = arr_q.pop_front();
                        check("arrival_floor", int'(CurrentFloor), a.floor);
                        check("arrival_udin", int'(UDIn), a.ud);
                        check("move_cycles", move_cnt, a.move_len);
                    end
                    move_cnt = 0;
                end
                if (Delay) dly_cnt++;
                if (!Delay && prev_delay) begin
                    exp_len = (dly_q.size() != 0) ? dly_q.pop_front() : -1;
                    check("arrive_cycles", dly_cnt, exp_len);
                    dly_cnt = 0;
                end
                if (DoorOpen) door_cnt++;
                if (!DoorOpen && prev_door) begin
                    exp_len = (door_q.size() != 0) ? door_q.pop_front() : -1;
                    check("door_cycles", door_cnt, exp_len);
                    check("stop_after_door", int'(Stop), 1);
                    door_cnt = 0;
                end
                prev_delay = Delay;
                prev_door = DoorOpen;
            end
        end
    end

    initial begin
        bit more;
        int iter;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // Floor 0 up, then door at floor 1.
        start_trip(1);
        arrive_exit(0, 0, more);
        check("door_floor1", int'(CurrentFloor), 1);
        // Up to floor 2, back-to-back down to floor 1, idle.
        start_trip(1);
        arrive_exit(1, 0, more);
        arrive_exit(2, 0, more);
        // Climb to 3, then an up request at the top arrives in place.
        start_trip(1);
        arrive_exit(2, 0, more);
        start_trip(1);
        arrive_exit(2, 0, more);
        start_trip(1);
        arrive_exit(2, 0, more);
        check("top_floor_hold", int'(CurrentFloor), 3);
        // Door with a reopen pulse on dwell cycle 2.
        start_trip(0);
        arrive_exit(3, 0, more);
        // Down to floor 0, then a down request at the bottom arrives in place.
        start_trip(0);
        arrive_exit(1, 0, more);
        arrive_exit(2, 0, more);
        start_trip(0);
        arrive_exit(2, 0, more);
        check("bottom_floor_hold", int'(CurrentFloor), 0);

        // Reset pulsed mid-MOVE takes effect without a clock edge.
        start_trip(1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_values("mid_move_reset");
        void'(arr_q.pop_back());
        m_floor = 0;
        m_ud = 0;
        @(negedge clk);
        #1 rst = 1'b0;

        for (int t = 0; t < 30; t++) begin
            start_trip(int'($urandom_range(0, 1)));
            iter = 0;
            do begin
                arrive_exit((iter < 6) ? int'($urandom_range(0, 2)) : 2,
                            int'($urandom_range(0, 1)), more);
                iter++;
            end while (more);
        end

        repeat (3) @(negedge clk);
        check("arr_q_drained", arr_q.size(), 0);
        check("dly_q_drained", dly_q.size(), 0);
        check("door_q_drained", door_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/elevator_car_controller.md
# elevator_car_controller

Car motion and door sequencer directly downstream of the request memory manager. It consumes the direction, door and start requests, and models one floor of travel per `TRAVEL_CYCLES` and a fixed door dwell. It produces the floor position, direction, arrival and idle signals that the memory manager reads back. All outputs are registered (Moore).

## Interface
Parameters:
- `TRAVEL_CYCLES`, default 1000: cycles to move one floor; must be ≥ 1.
- `DOOR_CYCLES`, default 2000: cycles the door stays open; must be ≥ 1.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `OCRequest` in 1: door-open request (level).
- `UDRequest` in 1: requested direction; 1 = up, 0 = down.
- `NoStopRequest` in 1: start/resume-motion request (level).
- `DoneDelay` in 1: manager has processed the current arrival.
- `CurrentFloor` out 2: car floor, 0–3.
- `UDIn` out 1: direction of last/current travel.
- `Delay` out 1: arrival at a floor, pending manager acknowledge.
- `Stop` out 1: car idle, doors closed.
- `DoorOpen` out 1: door open.
- `Moving` out 1: car travelling.

## Operation
States: IDLE, MOVE, ARRIVE, DOOR.
- Reset (async): state IDLE, `CurrentFloor`=0, `UDIn`=0, `Stop`=1, `Delay`=0, `DoorOpen`=0, `Moving`=0, timer=0.
- Legal move: `UDRequest`=1 with `CurrentFloor`<3, or `UDRequest`=0 with `CurrentFloor`>0.
- IDLE (`Stop`=1):
  - `NoStopRequest`=1 and legal move → MOVE; `UDIn`←`UDRequest`; timer←0.
  - `NoStopRequest`=1 and illegal move (car already at the requested end) → ARRIVE; floor unchanged. This lets the manager service a call at the current floor.
  - `OCRequest` alone is ignored in IDLE.
- MOVE (`Moving`=1): timer increments each cycle. When timer = `TRAVEL_CYCLES`−1, `CurrentFloor`←`CurrentFloor`±1 per `UDIn`, timer←0, state → ARRIVE. Inputs are ignored during MOVE.
- ARRIVE (`Delay`=1): hold until `DoneDelay`=1 is sampled. Then, in priority order:
  - `OCRequest`=1 → DOOR, timer←0.
  - else `NoStopRequest`=1 and legal move → MOVE, `UDIn`←`UDRequest`.
  - else → IDLE.
- DOOR (`DoorOpen`=1): timer increments. At timer = `DOOR_CYCLES`−1 → IDLE, timer←0.
- Floor arithmetic is 2-bit and never wraps; the legality check prevents 3→0 and 0→3.
- Timer width is `$clog2(max(TRAVEL_CYCLES,DOOR_CYCLES))`+1 bits.
- Exactly one of `Stop`/`Moving`/`Delay`/`DoorOpen` is 1 in every cycle.

## Timing
- Every output changes only on a `clk` edge, or asynchronously on `rst`.
- IDLE→MOVE: `Moving` rises on the edge after `NoStopRequest` is sampled high.
- MOVE lasts exactly `TRAVEL_CYCLES` cycles. `CurrentFloor` updates on the same edge that `Delay` rises.
- ARRIVE lasts at least 1 cycle. A `DoneDelay` that is already high exits ARRIVE after exactly 1 cycle.
- DOOR lasts exactly `DOOR_CYCLES` cycles (base build). `Stop` rises on the following edge.
- Reset asserted mid-MOVE or mid-DOOR aborts immediately to reset values; a partial floor is discarded and `CurrentFloor` returns to 0.
- Simultaneous `OCRequest` and `NoStopRequest` at ARRIVE exit: the door wins.

## Configuration
- `ELEVATOR_DOOR_REOPEN_EN` defined:
  - An extra register samples `OCRequest`.
  - In DOOR, a rising edge of `OCRequest` (0 in previous cycle, 1 now) resets the timer to 0, extending the dwell by a full `DOOR_CYCLES` from that edge.
  - A rising edge coincident with expiry also restarts the dwell.
- `ELEVATOR_DOOR_REOPEN_EN` undefined: `OCRequest` is ignored in DOOR; dwell is fixed.

## Test plan
Bench uses `TRAVEL_CYCLES`=4, `DOOR_CYCLES`=3.
- Reset → `CurrentFloor`=0, `Stop`=1, all other outputs 0. Pulse `rst` during MOVE → same values within the reset assertion, with no clock edge required.
- IDLE, floor 0, `NoStopRequest`=1, `UDRequest`=1 → `Moving` high for 4 cycles. Then `CurrentFloor`=1 and `Delay`=1, held high until `DoneDelay`=1.
- ARRIVE at floor 1, `DoneDelay`=1, `OCRequest`=1 → `DoorOpen`=1 for exactly 3 cycles, then `Stop`=1, `CurrentFloor`=1.
- Floor 3, IDLE, `NoStopRequest`=1, `UDRequest`=1 → ARRIVE with `CurrentFloor` staying 3; no `Moving` pulse. Same check at floor 0 with `UDRequest`=0.
- ARRIVE at floor 2, `DoneDelay`=1, `OCRequest`=0, `NoStopRequest`=1, `UDRequest`=0 → back-to-back MOVE with `UDIn`=0, then `CurrentFloor`=1 after 4 cycles.
- With `ELEVATOR_DOOR_REOPEN_EN`: in DOOR, `OCRequest` 0→1 on dwell cycle 2 → `DoorOpen` stays high 3 further cycles (5 total). Without the macro → 3 total.
